// File: rtl/memory_stage.sv
// Memory stage of an in-order pipeline: drives a valid/ready data-memory port for loads and
// stores, stalls upstream while an access is in flight and registers results for writeback.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_reg_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2_data,
  input  logic [3:0]  in_mem_op,
  input  logic        in_rf_wen,
  input  logic [3:0]  in_wb_sel,
  input  logic [4:0]  in_wb_addr,
  input  logic [2:0]  in_csr_cmd,
  input  logic        in_jmp_flg,
  input  logic [31:0] in_imm_i,
  input  logic [31:0] in_op1_data,
  input  logic        in_inst_is_ecall,
  input  logic        flush,
  output logic        mem_stall,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] out_reg_pc,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_mem_rdata,
  output logic        out_rf_wen,
  output logic [3:0]  out_wb_sel,
  output logic [4:0]  out_wb_addr,
  output logic [2:0]  out_csr_cmd,
  output logic        out_jmp_flg,
  output logic [31:0] out_imm_i,
  output logic [31:0] out_op1_data,
  output logic        out_inst_is_ecall,
  output logic        out_misalign
);

  localparam logic [3:0] OpSb  = 4'd1;
  localparam logic [3:0] OpSh  = 4'd2;
  localparam logic [3:0] OpSw  = 4'd3;
  localparam logic [3:0] OpLb  = 4'd4;
  localparam logic [3:0] OpLbu = 4'd5;
  localparam logic [3:0] OpLh  = 4'd6;
  localparam logic [3:0] OpLhu = 4'd7;
  localparam logic [3:0] OpLw  = 4'd8;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [3:0]  mem_op;
    logic        rf_wen;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp_flg;
    logic [31:0] imm;
    logic [31:0] op1;
    logic        ecall;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        rf_wen;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp_flg;
    logic [31:0] imm;
    logic [31:0] op1;
    logic        ecall;
    logic        misalign;
  } out_t;

  function automatic out_t pass_through(input instr_t i);
    out_t o;
    o          = '0;
    o.pc       = i.pc;
    o.alu      = i.alu;
    o.rf_wen   = i.rf_wen;
    o.wb_sel   = i.wb_sel;
    o.wb_addr  = i.wb_addr;
    o.csr_cmd  = i.csr_cmd;
    o.jmp_flg  = i.jmp_flg;
    o.imm      = i.imm;
    o.op1      = i.op1;
    o.ecall    = i.ecall;
    return o;
  endfunction

  state_e state_q, state_d;
  instr_t hold_q, hold_d, in_s, src;
  out_t   out_q, out_d;
  logic   kill_q, kill_d;

  logic        is_store, is_load, valid_op, misalign;
  logic        issue, accept, complete, kill;
  logic [1:0]  a;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_data;

  assign in_s = '{pc: in_reg_pc, alu: in_alu_out, rs2: in_rs2_data, mem_op: in_mem_op,
                  rf_wen: in_rf_wen, wb_sel: in_wb_sel, wb_addr: in_wb_addr,
                  csr_cmd: in_csr_cmd, jmp_flg: in_jmp_flg, imm: in_imm_i,
                  op1: in_op1_data, ecall: in_inst_is_ecall};

  // Once a request is out, the request fields come from the hold registers so they stay stable.
  always_comb begin
    src      = (state_q == StIdle) ? in_s : hold_q;
    a        = src.alu[1:0];
    is_store = (src.mem_op >= OpSb) && (src.mem_op <= OpSw);
    is_load  = (src.mem_op >= OpLb) && (src.mem_op <= OpLw);
    valid_op = is_store || is_load;
    case (src.mem_op)
      OpSh, OpLh, OpLhu: misalign = a[0];
      OpSw, OpLw:        misalign = |a;
      default:           misalign = 1'b0;
    endcase
  end

  always_comb begin
    dmem_addr = {src.alu[31:2], 2'b00};
    dmem_wen  = is_store;
    case (src.mem_op)
      OpSb: begin
        dmem_wmask = 4'b0001 << a;
        dmem_wdata = {4{src.rs2[7:0]}};
      end
      OpSh: begin
        dmem_wmask = a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{src.rs2[15:0]}};
      end
      OpSw: begin
        dmem_wmask = 4'b1111;
        dmem_wdata = src.rs2;
      end
      default: begin
        dmem_wmask = 4'b0000;
        dmem_wdata = 32'h0;
      end
    endcase
  end

  always_comb begin
    lb = 8'(dmem_rdata >> {a, 3'b000});
    lh = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (src.mem_op)
      OpLb:    load_data = {{24{lb[7]}}, lb};
      OpLbu:   load_data = {24'h0, lb};
      OpLh:    load_data = {{16{lh[15]}}, lh};
      OpLhu:   load_data = {16'h0, lh};
      OpLw:    load_data = dmem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    issue      = (state_q == StIdle) && valid_op && !misalign && !flush;
    dmem_valid = issue || (state_q == StReq);
    accept     = dmem_valid && dmem_ready;
    complete   = (accept && (is_store || dmem_rvalid)) || ((state_q == StResp) && dmem_rvalid);
    kill       = flush || kill_q;
    mem_stall  = (dmem_valid || (state_q == StResp)) && !complete;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (issue) begin
          hold_d = in_s;
          if (complete)    state_d = StIdle;
          else if (accept) state_d = StResp;
          else             state_d = StReq;
        end
      end
      StReq: begin
        if (accept)     state_d = complete ? StIdle : StResp;
        else if (flush) state_d = StIdle;
      end
      StResp: begin
        if (dmem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A flushed access still in flight must drain its response and then retire as a bubble.
    kill_d = (state_d != StIdle) && (kill_q || flush);
  end

  always_comb begin
    out_d = '0;
    if ((state_q == StIdle) && !issue) begin
      if (!flush) begin
        out_d          = pass_through(in_s);
        out_d.misalign = valid_op && misalign;
        out_d.rf_wen   = in_s.rf_wen && !(valid_op && misalign);
      end
    end else if (complete && !kill) begin
      out_d       = pass_through(src);
      out_d.rdata = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      kill_q  <= 1'b0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign out_reg_pc        = out_q.pc;
  assign out_alu_out       = out_q.alu;
  assign out_mem_rdata     = out_q.rdata;
  assign out_rf_wen        = out_q.rf_wen;
  assign out_wb_sel        = out_q.wb_sel;
  assign out_wb_addr       = out_q.wb_addr;
  assign out_csr_cmd       = out_q.csr_cmd;
  assign out_jmp_flg       = out_q.jmp_flg;
  assign out_imm_i         = out_q.imm;
  assign out_op1_data      = out_q.op1;
  assign out_inst_is_ecall = out_q.ecall;
  assign out_misalign      = out_q.misalign;

endmodule
